// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Operation codes follow the MCycleOp port; states drive the iteration FSM.
package mcycle_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCompute = 2'b01,
        StDone    = 2'b10
    } mcycle_state_e;

endpackage

// File: rtl/muldiv_step.sv
// Single combinational iteration: shift-add for multiply, restoring trial-subtract for divide.
// Divide keeps {remainder, dividend/quotient} in i_acc and the divisor in i_mcand[WIDTH-1:0].
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [2*WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [2*WIDTH-1:0]   o_mcand,
    output logic [WIDTH-1:0]     o_mplier
);

    logic [2*WIDTH-1:0] w_sum;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_divisor;
    logic [WIDTH-1:0]   w_diff;
    logic               w_fits;

    assign w_sum       = i_acc + i_mcand;
    // Remainder after shifting in the next dividend bit; needs one extra bit.
    assign w_rem_shift = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_divisor   = {1'b0, i_mcand[WIDTH-1:0]};
    assign w_fits      = (w_rem_shift >= w_divisor);
    assign w_diff      = WIDTH'(w_rem_shift - w_divisor);

    always_comb begin
        o_acc    = i_acc;
        o_mcand  = i_mcand;
        o_mplier = i_mplier;
        if (i_is_div) begin
            if (w_fits) begin
                o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (i_mplier[0]) begin
                o_acc = w_sum;
            end
            o_mcand  = i_mcand << 1;
            o_mplier = i_mplier >> 1;
        end
    end

endmodule

// File: rtl/mcycle_muldiv.sv
// Iterative RV32M multiply/divide unit with a Start/Busy/Done handshake.
// Operands are latched as magnitudes; signs are reapplied when the last iteration completes.
module mcycle_muldiv
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    mcycle_state_e      r_state, w_state_nxt;
    logic               r_is_div, w_is_div_nxt;
    logic               r_neg_q, w_neg_q_nxt;
    logic               r_neg_r, w_neg_r_nxt;
    logic [CW-1:0]      r_count, w_count_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [2*WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [WIDTH-1:0]   r_result1, w_res1_nxt;
    logic [WIDTH-1:0]   r_result2, w_res2_nxt;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic               w_div_zero, w_div_ovf;
    logic [2*WIDTH-1:0] w_step_acc, w_step_mcand;
    logic [WIDTH-1:0]   w_step_mplier;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_a_neg    = ~MCycleOp[0] & Operand1[WIDTH-1];
    assign w_b_neg    = ~MCycleOp[0] & Operand2[WIDTH-1];
    assign w_mag1     = w_a_neg ? -Operand1 : Operand1;
    assign w_mag2     = w_b_neg ? -Operand2 : Operand2;
    assign w_div_zero = MCycleOp[1] && (Operand2 == '0);
    assign w_div_ovf  = (MCycleOp == OP_DIV) && (Operand1 == {1'b1, {(WIDTH-1){1'b0}}})
                        && (&Operand2);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_step_acc),
        .o_mcand  (w_step_mcand),
        .o_mplier (w_step_mplier)
    );

    assign w_prod = r_neg_q ? -w_step_acc : w_step_acc;
    assign w_quo  = r_neg_q ? -w_step_acc[WIDTH-1:0] : w_step_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_step_acc[2*WIDTH-1:WIDTH] : w_step_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt  = r_state;
        w_is_div_nxt = r_is_div;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_count_nxt  = r_count;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_res1_nxt   = r_result1;
        w_res2_nxt   = r_result2;
        unique case (r_state)
            StIdle, StDone: begin
                if (Start) begin
                    w_is_div_nxt = MCycleOp[1];
                    w_count_nxt  = '0;
                    w_neg_q_nxt  = w_a_neg ^ w_b_neg;
                    w_neg_r_nxt  = w_a_neg;
                    if (MCycleOp[1]) begin
                        w_acc_nxt    = {{WIDTH{1'b0}}, w_mag1};
                        w_mcand_nxt  = {{WIDTH{1'b0}}, w_mag2};
                        w_mplier_nxt = '0;
                    end else begin
                        w_acc_nxt    = '0;
                        w_mcand_nxt  = {{WIDTH{1'b0}}, w_mag1};
                        w_mplier_nxt = w_mag2;
                    end
                    if (w_div_zero) begin
                        w_state_nxt = StDone;
                        w_res1_nxt  = '1;
                        w_res2_nxt  = Operand1;
                    end else if (w_div_ovf) begin
                        w_state_nxt = StDone;
                        w_res1_nxt  = Operand1;
                        w_res2_nxt  = '0;
                    end else begin
                        w_state_nxt = StCompute;
                    end
                end else if (r_state == StDone) begin
                    w_state_nxt = StIdle;
                end
            end
            StCompute: begin
                w_acc_nxt    = w_step_acc;
                w_mcand_nxt  = w_step_mcand;
                w_mplier_nxt = w_step_mplier;
                w_count_nxt  = r_count + CW'(1);
                if (r_count == CNT_LAST) begin
                    w_state_nxt = StDone;
                    if (r_is_div) begin
                        w_res1_nxt = w_quo;
                        w_res2_nxt = w_rem;
                    end else begin
                        w_res1_nxt = w_prod[WIDTH-1:0];
                        w_res2_nxt = w_prod[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= StIdle;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_result1 <= '0;
            r_result2 <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_is_div  <= w_is_div_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_count   <= w_count_nxt;
            r_acc     <= w_acc_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_result1 <= w_res1_nxt;
            r_result2 <= w_res2_nxt;
        end
    end

    assign Result1 = r_result1;
    assign Result2 = r_result2;
    assign Busy    = (r_state == StCompute);
    assign Done    = (r_state == StDone);

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Directed-vector bench for mcycle_muldiv at WIDTH=32 with hand-computed results.
module tb_mcycle_muldiv;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  MCycleOp = 2'b00;
    logic [31:0] Operand1 = '0;
    logic [31:0] Operand2 = '0;
    logic [31:0] Result1, Result2;
    logic        Busy, Done;

    int n_cmp = 0;
    int n_err = 0;

    mcycle_muldiv #(
        .WIDTH (32)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns #1 after the sampling edge with operands scrambled.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        @(posedge CLK);
        #1;
        Start    = 1'b0;
        MCycleOp = ~op;
        Operand1 = $urandom;
        Operand2 = $urandom;
    endtask

    // Counts negedges after the Start edge until Done; returns at the negedge where Done is seen.
    task automatic wait_done(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input int e_lat, input int e_busy);
        int lat = 0;
        int busy = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            lat++;
            if (Busy) busy++;
            if (Done) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " busy"}, 64'(busy), 64'(e_busy));
        check({tag, " Result1"}, 64'(Result1), 64'(e1));
        check({tag, " Result2"}, 64'(Result2), 64'(e2));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                          input int e_lat, input int e_busy);
        @(negedge CLK);
        issue(op, a, b);
        wait_done(tag, e1, e2, e_lat, e_busy);
        @(negedge CLK);
        check({tag, " done pulse"}, 64'(Done), 64'(0));
    endtask

    initial begin
        int done_seen;

        #12;
        check("reset Busy", 64'(Busy), 64'(0));
        check("reset Done", 64'(Done), 64'(0));
        check("reset Result1", 64'(Result1), 64'(0));
        check("reset Result2", 64'(Result2), 64'(0));
        @(negedge CLK);
        RESET = 1'b0;

        run_op("smul -7*6", 2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 33, 32);
        repeat (3) @(negedge CLK);
        check("hold in idle", 64'(Result1), 64'h0000_0000_FFFF_FFD6);
        run_op("umul max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE,
               33, 32);
        run_op("umul 2^16*2^16", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 33, 32);
        run_op("sdiv -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 32);
        run_op("sdiv 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 32);
        run_op("udiv 100/7", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 33, 32);
        run_op("udiv by 0", 2'b11, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 0);
        run_op("sdiv -7 by 0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 0);
        run_op("sdiv ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1, 0);

        // Start pulsed while computing must not disturb the running op.
        @(negedge CLK);
        issue(2'b01, 32'd3, 32'd5);
        repeat (5) @(negedge CLK);
        issue(2'b11, 32'd50, 32'd5);
        wait_done("ignore mid start", 32'd15, 32'd0, 28, 27);

        // Back-to-back: second op issued in the first op's Done cycle.
        @(negedge CLK);
        issue(2'b00, 32'd3, 32'hFFFF_FFFC);
        wait_done("b2b first", 32'hFFFF_FFF4, 32'hFFFF_FFFF, 33, 32);
        issue(2'b11, 32'd1000, 32'd10);
        wait_done("b2b second", 32'd100, 32'd0, 33, 32);
        @(negedge CLK);
        check("b2b done pulse", 64'(Done), 64'(0));

        // Reset during a multiply.
        @(negedge CLK);
        issue(2'b00, 32'hFFFF_FFF9, 32'd6);
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("midreset Busy", 64'(Busy), 64'(0));
        check("midreset Done", 64'(Done), 64'(0));
        check("midreset Result1", 64'(Result1), 64'(0));
        check("midreset Result2", 64'(Result2), 64'(0));
        @(negedge CLK);
        RESET = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done || Busy) done_seen++;
        end
        check("no done after reset", 64'(done_seen), 64'(0));
        run_op("udiv after reset", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 33, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
